bias_quant_pipe: RTL

- Parametrised, pipelined successor to the combinational bias-add/quantize stage that follows the ReLU in the neuron grid.
- Serves N_CH neuron channels time-multiplexed on one stream. Each sample carries a channel index and picks up that channel's stored signed bias.
- Result is right-shifted, ReLU-clamped and saturated to DOUT_W bits.
- Uses valid/ready handshakes on both sides and counts saturation events.

---
 rtl/bias_quant_pkg.sv | 33 +++
 rtl/bias_quant_pipe_bias_rf.sv | 53 +++++
 rtl/bias_quant_pipe.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bias_quant_pkg.sv
// bias_quant_pkg: shared defaults and helpers for the bias/quantize pipe.
// Holds channel-width derivation and the unsigned saturate helper.
package bias_quant_pkg;

  localparam int N_CH_DEF   = 8;
  localparam int DIN_W_DEF  = 18;
  localparam int BIAS_W_DEF = 8;
  localparam int DOUT_W_DEF = 8;
  localparam int SHIFT_DEF  = 10;
  localparam int CNT_W_DEF  = 16;

  // Index width for n channels, never narrower than one bit.
  function automatic int ch_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // Clip q to w bits unsigned.
  // Returns {clipped, value}; value is all ones when clipped.
  function automatic logic [32:0] sat_u(
    input logic [63:0] q,
    input int          w
  );
    logic [63:0] maxv;
    maxv = (64'd1 << w) - 64'd1;
    if (q > maxv) begin
      return {1'b1, maxv[31:0]};
    end
    return {1'b0, q[31:0]};
  endfunction

endpackage

// File: rtl/bias_quant_pipe_bias_rf.sv
// bias_rf: per-channel signed bias storage, cleared by reset.
// One write port, one combinational read port; old value seen on collision.
module bias_rf
  import bias_quant_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int BIAS_W = BIAS_W_DEF,
  parameter int CH_W   = ch_width(N_CH_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [CH_W-1:0]   waddr,
  input  logic [BIAS_W-1:0] wdata,
  input  logic [CH_W-1:0]   raddr,
  output logic [BIAS_W-1:0] rdata
);

  logic [BIAS_W-1:0] bias_q [N_CH];
  logic [BIAS_W-1:0] bias_d [N_CH];

  logic waddr_ok;
  logic raddr_ok;

  assign waddr_ok = (32'(waddr) < N_CH);
  assign raddr_ok = (32'(raddr) < N_CH);

  // Next RF contents: out-of-range write addresses are dropped.
  always_comb begin
    bias_d = bias_q;
    if (we && waddr_ok) begin
      bias_d[waddr] = wdata;
    end
  end

  // Register file state, cleared to zero bias on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_q <= '{default: '0};
    end else begin
      bias_q <= bias_d;
    end
  end

  // Out-of-range channels read as zero bias.
  always_comb begin
    rdata = '0;
    if (raddr_ok) begin
      rdata = bias_q[raddr];
    end
  end

endmodule

// File: rtl/bias_quant_pipe.sv
// bias_quant_pipe: two-stage bias add, ReLU, shift and saturate.
// Define BIAS_QUANT_ROUND_EN for round-half-up instead of truncation.
module bias_quant_pipe
  import bias_quant_pkg::*;
#(
  parameter int N_CH   = N_CH_DEF,
  parameter int DIN_W  = DIN_W_DEF,
  parameter int BIAS_W = BIAS_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF,
  parameter int SHIFT  = SHIFT_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  localparam int CH_W  = ch_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DIN_W-1:0]  s_data,
  input  logic [CH_W-1:0]   s_ch,
  input  logic              bias_we,
  input  logic [CH_W-1:0]   bias_waddr,
  input  logic [BIAS_W-1:0] bias_wdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DOUT_W-1:0] m_data,
  output logic [CH_W-1:0]   m_ch,
  output logic              m_sat,
  output logic [CNT_W-1:0]  sat_cnt,
  input  logic              sat_clr
);

  // Sum width: one bit for bias headroom, one sign bit.
  localparam int SUM_W = DIN_W + 2;

  localparam logic [SUM_W:0] RND_HALF =
    (SUM_W+1)'(1) << (SHIFT - 1);

  logic [BIAS_W-1:0] bias_rd;

  logic              v1_q, v1_d;
  logic [SUM_W-1:0]  sum1_q, sum1_d;
  logic [CH_W-1:0]   ch1_q, ch1_d;

  logic              v2_q, v2_d;
  logic [DOUT_W-1:0] dat2_q, dat2_d;
  logic [CH_W-1:0]   ch2_q, ch2_d;
  logic              sat2_q, sat2_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic ld1, ld2;
  logic s_xfer, m_xfer;

  logic [SUM_W:0]    qsum;
  logic [63:0]       q64;
  logic [32:0]       sres;

  bias_rf #(
    .N_CH   (N_CH),
    .BIAS_W (BIAS_W),
    .CH_W   (CH_W)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (bias_we),
    .waddr (bias_waddr),
    .wdata (bias_wdata),
    .raddr (s_ch),
    .rdata (bias_rd)
  );

  // Each stage loads when empty or when its content leaves this cycle.
  assign ld2     = !v2_q || m_ready;
  assign ld1     = !v1_q || ld2;
  assign s_ready = ld1;
  assign s_xfer  = s_valid && s_ready;
  assign m_xfer  = v2_q && m_ready;

  // Stage 1: zero-extended sample plus sign-extended channel bias.
  always_comb begin
    v1_d   = v1_q;
    sum1_d = sum1_q;
    ch1_d  = ch1_q;
    if (ld1) begin
      v1_d = s_valid;
    end
    if (s_xfer) begin
      sum1_d = {2'b00, s_data}
             + {{(SUM_W-BIAS_W){bias_rd[BIAS_W-1]}}, bias_rd};
      ch1_d  = s_ch;
    end
  end

  // Stage 2 arithmetic: negative sums clamp to zero, then shift.
  always_comb begin
    qsum = '0;
    if (!sum1_q[SUM_W-1]) begin
`ifdef BIAS_QUANT_ROUND_EN
      qsum = {1'b0, sum1_q} + RND_HALF;
`else
      qsum = {1'b0, sum1_q};
`endif
    end
    q64  = 64'(qsum >> SHIFT);
    sres = sat_u(q64, DOUT_W);
  end

  // Stage 2 register load; outputs hold while stalled.
  always_comb begin
    v2_d   = v2_q;
    dat2_d = dat2_q;
    ch2_d  = ch2_q;
    sat2_d = sat2_q;
    if (ld2) begin
      v2_d = v1_q;
      if (v1_q) begin
        dat2_d = sres[DOUT_W-1:0];
        ch2_d  = ch1_q;
        sat2_d = sres[32];
      end
    end
  end

  // Saturation event counter; clear wins, sticks at all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = '0;
    end else if (m_xfer && sat2_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pipeline and counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      sum1_q <= '0;
      ch1_q  <= '0;
      v2_q   <= 1'b0;
      dat2_q <= '0;
      ch2_q  <= '0;
      sat2_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      sum1_q <= sum1_d;
      ch1_q  <= ch1_d;
      v2_q   <= v2_d;
      dat2_q <= dat2_d;
      ch2_q  <= ch2_d;
      sat2_q <= sat2_d;
      cnt_q  <= cnt_d;
    end
  end

  assign m_valid = v2_q;
  assign m_data  = dat2_q;
  assign m_ch    = ch2_q;
  assign m_sat   = sat2_q;
  assign sat_cnt = cnt_q;

endmodule
